// File: rtl/txwregif_cmd_drain_if.sv
// rtl/txwregif_cmd_drain_if.sv - FIFO read port and register-write bus between drain and its neighbours
interface txwregif_cmd_drain_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
);
  logic              rdempty;
  logic              rden;
  logic [WIDTH-1:0]  dataout;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [3:0]        reg_be;
  logic [31:0]       reg_wdata;
  logic              reg_ack;

  modport master (
    input  rdempty, dataout, reg_ack,
    output rden, reg_wr, reg_addr, reg_be, reg_wdata
  );

  modport slave (
    output rdempty, dataout, reg_ack,
    input  rden, reg_wr, reg_addr, reg_be, reg_wdata
  );
endinterface

// File: rtl/txwregif_cmd_drain.sv
// rtl/txwregif_cmd_drain.sv - pops 3-word commands from the TX reg FIFO and issues one register write
// Optional ack timeout enabled by defining TXWREGIF_TIMEOUT_EN.
module txwregif_cmd_drain #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 12,
    parameter int TMO_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset_,
    txwregif_cmd_drain_if.master bus,
    output logic                 busy_o,
    output logic [15:0]          wr_cnt_o,
    output logic [7:0]           drop_cnt_o,
    output logic                 tmo_err_o,
    output logic                 dbg_o
);

  if (WIDTH != 16 || ADDR_W != WIDTH - 4 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_cfg
    $error("txwregif_cmd_drain: unsupported WIDTH/ADDR_W/TMO_CYC combination");
  end

  typedef enum logic [1:0] {IDLE, POP, CAP, ISSUE} state_e;

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              reg_wr_q;
  logic [15:0]       wr_cnt_q;
  logic [7:0]        drop_cnt_q;

`ifdef TXWREGIF_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
  logic [7:0] tmo_q;
  logic       tmo_err_q;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      be_q       <= 4'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      reg_wr_q   <= 1'b0;
      wr_cnt_q   <= 16'd0;
      drop_cnt_q <= 8'd0;
`ifdef TXWREGIF_TIMEOUT_EN
      tmo_q      <= 8'd0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
`ifdef TXWREGIF_TIMEOUT_EN
      tmo_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          idx_q   <= 2'd0;
          state_q <= POP;
        end
        POP: begin
          if (!bus.rdempty) state_q <= CAP;
        end
        CAP: begin
          // dataout holds the word popped in the preceding POP cycle
          case (idx_q)
            2'd0: begin
              be_q   <= bus.dataout[WIDTH-1 -: 4];
              addr_q <= bus.dataout[ADDR_W-1:0];
            end
            2'd1:    data_q[31:16] <= bus.dataout[15:0];
            default: data_q[15:0]  <= bus.dataout[15:0];
          endcase
          if (idx_q != 2'd2) begin
            idx_q   <= idx_q + 2'd1;
            state_q <= POP;
          end else if (be_q != 4'd0) begin
            reg_wr_q <= 1'b1;
            state_q  <= ISSUE;
`ifdef TXWREGIF_TIMEOUT_EN
            tmo_q    <= 8'd0;
`endif
          end else begin
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (bus.reg_ack) begin
            reg_wr_q <= 1'b0;
            wr_cnt_q <= wr_cnt_q + 16'd1;
            state_q  <= IDLE;
          end
`ifdef TXWREGIF_TIMEOUT_EN
          else if (tmo_q == TMO_LIM) begin
            reg_wr_q  <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rdempty keeps the FIFO from ever being read while empty
  assign bus.rden      = (state_q == POP) & ~bus.rdempty;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_be    = be_q;
  assign bus.reg_wdata = data_q;
  assign busy_o        = (state_q != IDLE);
  assign dbg_o         = (state_q == ISSUE);
  assign wr_cnt_o      = wr_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
`ifdef TXWREGIF_TIMEOUT_EN
  assign tmo_err_o     = tmo_err_q;
`else
  assign tmo_err_o     = 1'b0;
`endif

endmodule
